// File: rtl/rca_bist_ctrl.sv
// BIST and repair controller for a 4-bit reconfigurable ripple-carry adder with one spare stage.
// Optional macro RCA_BIST_EARLY_EXIT_EN: end the sweep as soon as a second faulty adder is implicated.
module rca_bist_ctrl #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] adder_sums,
    input  logic [3:0] adder_carrys,
    output logic       test,
    output logic [3:0] at,
    output logic [3:0] bt,
    output logic       cint,
    output logic [2:0] is,
    output logic [4:0] cs,
    output logic [3:0] ss,
    output logic       busy,
    output logic       done,
    output logic       fault_found,
    output logic [1:0] fault_idx,
    output logic       multi_fault
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        CHECK,
        DONE
    } state_t;

`ifdef RCA_BIST_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    localparam logic [3:0] WAIT_LAST   = 4'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);
    localparam logic [2:0] IS_HEALTHY  = 3'b111;
    localparam logic [4:0] CS_HEALTHY  = 5'b10000;
    localparam logic [3:0] SS_HEALTHY  = 4'b0000;

    state_t      state_q;
    logic [8:0]  vcnt_q;
    logic [3:0]  wcnt_q;
    logic        test_q;
    logic [3:0]  at_q;
    logic [3:0]  bt_q;
    logic        cint_q;
    logic [2:0]  is_q;
    logic [4:0]  cs_q;
    logic [3:0]  ss_q;
    logic        busy_q;
    logic        done_q;
    logic        found_q;
    logic [1:0]  idx_q;
    logic        multi_q;

    logic [4:0]  carryChain;
    logic [3:0]  expSum;
    logic [3:0]  expCar;
    logic [3:0]  mismatch;
    logic        blameHit;
    logic [1:0]  blameIdx;
    logic        firstBlame;
    logic        newMulti;
    logic [11:0] repairSel;

    // Golden ripple-carry result for the vector currently held on at/bt/cint.
    always_comb begin
        carryChain    = '0;
        expSum        = '0;
        carryChain[0] = cint_q;
        for (int i = 0; i < 4; i++) begin
            expSum[i]       = at_q[i] ^ bt_q[i] ^ carryChain[i];
            carryChain[i+1] = (at_q[i] & bt_q[i]) | (carryChain[i] & (at_q[i] ^ bt_q[i]));
        end
        expCar = carryChain[4:1];
    end

    // Blame the lowest mismatching stage: every stage below it produced a correct carry.
    always_comb begin
        mismatch = (adder_sums ^ expSum) | (adder_carrys ^ expCar);
        blameHit = |mismatch;
        blameIdx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mismatch[i]) begin
                blameIdx = 2'(i);
            end
        end
        firstBlame = (state_q == CHECK) && blameHit && !found_q && !multi_q;
        newMulti   = (state_q == CHECK) && blameHit && found_q && !multi_q && (blameIdx != idx_q);
    end

    always_comb begin
        repairSel = {IS_HEALTHY, CS_HEALTHY, SS_HEALTHY};
        if (found_q && !multi_q) begin
            case (idx_q)
                2'd0:    repairSel = {3'b000, 5'b00001, 4'b1111};
                2'd1:    repairSel = {3'b001, 5'b00010, 4'b1110};
                2'd2:    repairSel = {3'b011, 5'b00100, 4'b1100};
                default: repairSel = {3'b111, 5'b01000, 4'b1000};
            endcase
        end
    end

    // The first DONE cycle publishes the result; start is only honoured once busy has dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vcnt_q  <= '0;
            wcnt_q  <= '0;
            test_q  <= 1'b0;
            at_q    <= '0;
            bt_q    <= '0;
            cint_q  <= 1'b0;
            is_q    <= IS_HEALTHY;
            cs_q    <= CS_HEALTHY;
            ss_q    <= SS_HEALTHY;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            idx_q   <= '0;
            multi_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (state_q == DONE && busy_q) begin
                        test_q <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        {is_q, cs_q, ss_q} <= repairSel;
                    end else if (start) begin
                        state_q <= APPLY;
                        vcnt_q  <= '0;
                        found_q <= 1'b0;
                        idx_q   <= '0;
                        multi_q <= 1'b0;
                        is_q    <= IS_HEALTHY;
                        cs_q    <= CS_HEALTHY;
                        ss_q    <= SS_HEALTHY;
                        test_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                APPLY: begin
                    {at_q, bt_q, cint_q} <= vcnt_q;
                    wcnt_q  <= '0;
                    state_q <= (SETTLE_CYC > 0) ? WAIT : CHECK;
                end
                WAIT: begin
                    if (wcnt_q == WAIT_LAST) begin
                        state_q <= CHECK;
                    end else begin
                        wcnt_q <= wcnt_q + 4'd1;
                    end
                end
                CHECK: begin
                    if (firstBlame) begin
                        found_q <= 1'b1;
                        idx_q   <= blameIdx;
                    end else if (newMulti) begin
                        multi_q <= 1'b1;
                        found_q <= 1'b0;
                    end
                    if (vcnt_q == 9'd511 || (EARLY_EXIT && newMulti)) begin
                        state_q <= DONE;
                    end else begin
                        vcnt_q  <= vcnt_q + 9'd1;
                        state_q <= APPLY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign test        = test_q;
    assign at          = at_q;
    assign bt          = bt_q;
    assign cint        = cint_q;
    assign is          = is_q;
    assign cs          = cs_q;
    assign ss          = ss_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fault_found = found_q;
    assign fault_idx   = idx_q;
    assign multi_fault = multi_q;

endmodule

// File: tb/tb_rca_bist_ctrl.sv
// Testbench for rca_bist_ctrl: faulty ripple-carry adder model plus a done-driven scoreboard.
module tb_rca_bist_ctrl;

    localparam int SETTLE    = 1;
    localparam int SWEEP_CYC = 512 * (SETTLE + 2) + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] adderSums;
    logic [3:0] adderCarrys;
    logic       test;
    logic [3:0] at;
    logic [3:0] bt;
    logic       cint;
    logic [2:0] is;
    logic [4:0] cs;
    logic [3:0] ss;
    logic       busy;
    logic       done;
    logic       faultFound;
    logic [1:0] faultIdx;
    logic       multiFault;

    logic [3:0] sumSa0 = '0;
    logic [3:0] sumSa1 = '0;
    logic [3:0] carSa0 = '0;
    logic [3:0] carSa1 = '0;

    typedef struct {
        int         doneCyc;
        logic       found;
        logic [1:0] idx;
        logic       chkIdx;
        logic       multi;
        logic [2:0] isV;
        logic [4:0] csV;
        logic [3:0] ssV;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    rca_bist_ctrl #(.SETTLE_CYC(SETTLE)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .adder_sums(adderSums),
        .adder_carrys(adderCarrys),
        .test(test),
        .at(at),
        .bt(bt),
        .cint(cint),
        .is(is),
        .cs(cs),
        .ss(ss),
        .busy(busy),
        .done(done),
        .fault_found(faultFound),
        .fault_idx(faultIdx),
        .multi_fault(multiFault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Healthy ripple chain with per-stage stuck-at overrides; a stuck carry propagates downstream.
    always_comb begin
        logic c, s, co;
        adderSums   = '0;
        adderCarrys = '0;
        c = cint;
        for (int i = 0; i < 4; i++) begin
            s  = at[i] ^ bt[i] ^ c;
            co = (at[i] & bt[i]) | (c & (at[i] ^ bt[i]));
            if (sumSa0[i]) s = 1'b0;
            if (sumSa1[i]) s = 1'b1;
            if (carSa0[i]) co = 1'b0;
            if (carSa1[i]) co = 1'b1;
            adderSums[i]   = s;
            adderCarrys[i] = co;
            c = co;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: every rising done retires one expected result.
    initial begin
        logic prevDone;
        exp_t e;
        prevDone = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && prevDone !== 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("done_cycle", 32'(cyc), 32'(e.doneCyc));
                    checkOutput("busy_at_done", 32'(busy), 32'd0);
                    checkOutput("test_at_done", 32'(test), 32'd0);
                    checkOutput("fault_found", 32'(faultFound), 32'(e.found));
                    if (e.chkIdx) checkOutput("fault_idx", 32'(faultIdx), 32'(e.idx));
                    checkOutput("multi_fault", 32'(multiFault), 32'(e.multi));
                    checkOutput("is_sel", 32'(is), 32'(e.isV));
                    checkOutput("cs_sel", 32'(cs), 32'(e.csV));
                    checkOutput("ss_sel", 32'(ss), 32'(e.ssV));
                end
            end
            prevDone = done;
        end
    end

    // Configure faults, pulse start and queue the expected outcome (doneCyc is an offset from the start edge).
    task automatic applyStimulus(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] c0,
                                 input logic [3:0] c1, input exp_t e, input bit track,
                                 output int startCyc);
        @(negedge clk);
        sumSa0 = s0;
        sumSa1 = s1;
        carSa0 = c0;
        carSa1 = c1;
        start  = 1'b1;
        startCyc = cyc + 1;
        e.doneCyc = startCyc + e.doneCyc;
        if (track) expQ.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("done_timeout", 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
        @(negedge clk);
    endtask

    function automatic exp_t mkExp(input int offs, input logic found, input logic [1:0] idx,
                                   input logic chkIdx, input logic multi, input logic [2:0] isV,
                                   input logic [4:0] csV, input logic [3:0] ssV);
        exp_t e;
        e.doneCyc = offs;
        e.found   = found;
        e.idx     = idx;
        e.chkIdx  = chkIdx;
        e.multi   = multi;
        e.isV     = isV;
        e.csV     = csV;
        e.ssV     = ssV;
        return e;
    endfunction

    initial begin
        int   sc;
        int   earlyOffs;
        exp_t e;

        rst   = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        checkOutput("rst_test", 32'(test), 32'd0);
        checkOutput("rst_at", 32'(at), 32'd0);
        checkOutput("rst_bt", 32'(bt), 32'd0);
        checkOutput("rst_cint", 32'(cint), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_found", 32'(faultFound), 32'd0);
        checkOutput("rst_idx", 32'(faultIdx), 32'd0);
        checkOutput("rst_multi", 32'(multiFault), 32'd0);
        checkOutput("rst_is", 32'(is), 32'b111);
        checkOutput("rst_cs", 32'(cs), 32'b10000);
        checkOutput("rst_ss", 32'(ss), 32'b0000);

        $display("[TB] fault-free sweep");
        e = mkExp(SWEEP_CYC, 1'b0, 2'd0, 1'b1, 1'b0, 3'b111, 5'b10000, 4'b0000);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, e, 1'b1, sc);
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_test", 32'(test), 32'd1);
        waitIdle();

        $display("[TB] fa2 sum stuck-at-0, restarted from DONE");
        e = mkExp(SWEEP_CYC, 1'b1, 2'd2, 1'b1, 1'b0, 3'b011, 5'b00100, 4'b1100);
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000, e, 1'b1, sc);
        checkOutput("restart_done_low", 32'(done), 32'd0);
        checkOutput("restart_busy", 32'(busy), 32'd1);
        waitIdle();

        $display("[TB] fa0 carry stuck-at-1 with ignored mid-sweep start");
        e = mkExp(SWEEP_CYC, 1'b1, 2'd0, 1'b1, 1'b0, 3'b000, 5'b00001, 4'b1111);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0001, e, 1'b1, sc);
        repeat (99) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle();

        $display("[TB] fa1 and fa3 sum stuck-at-1");
`ifdef RCA_BIST_EARLY_EXIT_EN
        earlyOffs = (SETTLE + 2) * 4 + 1;
`else
        earlyOffs = SWEEP_CYC;
`endif
        e = mkExp(earlyOffs, 1'b0, 2'd0, 1'b0, 1'b1, 3'b111, 5'b10000, 4'b0000);
        applyStimulus(4'b0000, 4'b1010, 4'b0000, 4'b0000, e, 1'b1, sc);
        waitIdle();

        $display("[TB] reset in the middle of a sweep");
        e = mkExp(SWEEP_CYC, 1'b0, 2'd0, 1'b0, 1'b0, 3'b111, 5'b10000, 4'b0000);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b1000, e, 1'b0, sc);
        repeat (399) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_test", 32'(test), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_at", 32'(at), 32'd0);
        checkOutput("midrst_bt", 32'(bt), 32'd0);
        checkOutput("midrst_is", 32'(is), 32'b111);

        $display("[TB] fa3 carry stuck-at-0 after reset");
        e = mkExp(SWEEP_CYC, 1'b1, 2'd3, 1'b1, 1'b0, 3'b111, 5'b01000, 4'b1000);
        applyStimulus(4'b0000, 4'b0000, 4'b1000, 4'b0000, e, 1'b1, sc);
        waitIdle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
